// File: rtl/sync_fifo_flags.sv
// Synchronous single-clock FIFO with registered full/empty/almost flags,
// overflow/underflow pulses, and selectable registered or first-word fall-through read.
module sync_fifo_flags #(
  parameter int data_width = 8,
  parameter int fifo_depth = 32,
  parameter int addr_width = $clog2(fifo_depth),
  parameter int fwft       = 0,
  parameter int af_level   = fifo_depth - 2,
  parameter int ae_level   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [data_width-1:0] din,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [data_width-1:0] dout,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic [addr_width:0]   count
);

  localparam int cw = addr_width + 1;
  localparam logic [addr_width:0] depth_c = cw'(fifo_depth);
  localparam logic [addr_width:0] af_c    = cw'(af_level);
  localparam logic [addr_width:0] ae_c    = cw'(ae_level);

  logic [data_width-1:0] mem [fifo_depth];
  logic [addr_width-1:0] wr_ptr;
  logic [addr_width-1:0] rd_ptr;
  logic [addr_width:0]   count_next;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance uses the registered flags, so a full FIFO still accepts a read
  // and an empty FIFO still accepts a write in the same cycle.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_next = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count + cw'(1);
      2'b01:   count_next = count - cw'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + addr_width'(1);
      if (rd_acc) rd_ptr <= rd_ptr + addr_width'(1);
      count        <= count_next;
      full         <= (count_next == depth_c);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= af_c);
      almost_empty <= (count_next <= ae_c);
      overflow     <= wr_en && full;
      underflow    <= rd_en && empty;
    end
  end

  // NOTE: storage is deliberately not reset; cleared pointers make stale words unreachable.
  always_ff @(posedge clk) begin
    if (rst && wr_acc) mem[wr_ptr] <= din;
  end

  generate
    if (fwft != 0) begin : g_fwft
      // Head word is presented combinationally; zero while empty keeps the reset value clean.
      assign dout = empty ? '0 : mem[rd_ptr];
    end else begin : g_reg
      logic [data_width-1:0] dout_q;

      always_ff @(posedge clk) begin
        if (!rst) begin
          dout_q <= '0;
        end else if (rd_acc) begin
          dout_q <= mem[rd_ptr];
        end
      end

      assign dout = dout_q;
    end
  endgenerate

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 Parameter data_width, default 8, word width in bits (>=1).
REQ-002 Parameter fifo_depth, default 32, number of entries; power of two, >=4.
REQ-003 Parameter addr_width, default log2(fifo_depth), pointer width.
REQ-004 Parameter fwft, default 0, read mode: 0 = registered read, 1 = first-word fall-through.
REQ-005 Parameter af_level, default fifo_depth-2, count at or above which almost_full asserts; range 1..fifo_depth.
REQ-006 Parameter ae_level, default 2, count at or below which almost_empty asserts; range 0..fifo_depth-1.
REQ-007 clk  input  1  single clock; all state changes on its rising edge.
REQ-008 rst  input  1  reset; synchronous and active-low.
REQ-009 wr_en  input  1  write request.
REQ-010 din  input  data_width  write data.
REQ-011 full  output  1  count == fifo_depth.
REQ-012 almost_full  output  1  count >= af_level.
REQ-013 overflow  output  1  one-cycle pulse on a rejected write.
REQ-014 rd_en  input  1  read request.
REQ-015 dout  output  data_width  read data.
REQ-016 empty  output  1  count == 0.
REQ-017 almost_empty  output  1  count <= ae_level.
REQ-018 underflow  output  1  one-cycle pulse on a rejected read.
REQ-019 count  output  addr_width+1  current occupancy, 0..fifo_depth.

Function
REQ-020 Storage is a fifo_depth x data_width array with wr_ptr and rd_ptr of addr_width bits that wrap from fifo_depth-1 to 0.
REQ-021 A write is accepted iff wr_en && !full; an accepted write stores din at wr_ptr and increments wr_ptr.
REQ-022 A read is accepted iff rd_en && !empty; an accepted read increments rd_ptr.
REQ-023 full, empty, almost_full, almost_empty are registered and reflect the post-edge count; they contain no combinational path from wr_en or rd_en.
REQ-024 count: +1 on write-only, -1 on read-only, unchanged on both-accepted or neither.
REQ-025 Simultaneous wr_en and rd_en when full: the read is accepted, the write is rejected, overflow pulses, and count becomes fifo_depth-1.
REQ-026 Simultaneous wr_en and rd_en when empty: the write is accepted, the read is rejected, underflow pulses, and count becomes 1.
REQ-027 Simultaneous wr_en and rd_en when neither full nor empty: both are accepted and count is unchanged.
REQ-028 overflow is high for exactly the cycle after an edge on which wr_en && full; underflow likewise for rd_en && empty; pointers, count and memory are unchanged by rejected requests.
REQ-029 fwft=0: on an accepted read, dout loads mem[rd_ptr] at that edge (1-cycle latency); otherwise dout holds its value.
REQ-030 fwft=1: dout continuously presents mem[rd_ptr] while !empty; an accepted read advances it to the next word in the same edge (0-cycle latency).
REQ-031 fwft=1: when empty, dout value is don't-care.
REQ-032 Write-to-read: a word written into an empty FIFO is readable (empty low) on the cycle after the write edge.

Reset
REQ-033 An edge with rst low clears wr_ptr, rd_ptr and count, and drives empty=1, almost_empty=1, full=0, almost_full=0 (given af_level>=1), overflow=0, underflow=0, and dout=0.
REQ-034 Reset overrides any concurrent wr_en or rd_en; memory contents are not cleared, and stale words are never readable after reset.
REQ-035 Reset asserted mid-operation (non-empty or full) produces the state of REQ-033 on the next edge, and normal operation resumes on the first edge with rst high.

Verification
REQ-036 fifo_depth=4, fwft=0: reset, write A1,A2,A3,A4 -> full=1 and count=4 after the 4th edge; a 5th write -> overflow pulses for 1 cycle and count stays 4.
REQ-037 Continuing: 4 reads -> dout = A1,A2,A3,A4, each on the cycle after its read edge, and empty=1 after the 4th; a 5th read -> underflow pulse and dout holds A4.
REQ-038 fwft=1, depth 4: write B1 -> next cycle empty=0 and dout=B1 with no rd_en; rd_en with write B2 in the same cycle -> dout=B2 and count=1.
REQ-039 Full with wr_en=rd_en=1 -> count=3, overflow=1, oldest word popped; empty with both -> count=1, underflow=1.
REQ-040 af_level=3, ae_level=1, depth 4: walk count 0->4->0 and check almost_full high for counts 3-4 and almost_empty high for counts 0-1 at every step.
REQ-041 Pointer wrap: run 10 write/read pairs at depth 4 and check data order is preserved; assert reset at count=2 -> next cycle empty=1 and count=0, a subsequent write/read returns the new word.
